// File: rtl/dilatacion_ctrl.sv
// -----------------------------------------------------------------------------
// dilatacion_ctrl
// Sequencer for the 5-input max comparator of the dilation filter. It scans a
// grayscale frame in a synchronous-read source RAM. For each pixel it gathers
// the cross neighbourhood (center, up, down, left, right), with edge
// replication. It presents the operands to an external comparator, then writes
// the comparator result to a destination RAM. Cadence is 8 cycles per pixel.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   start              begin a frame (sampled in IDLE only)
//   busy, done         frame in progress / one-cycle end-of-frame pulse
//   rd_addr, rd_data   source RAM read port (data valid 1 cycle after addr)
//   wr_ready           destination ready; present only with the macro below
//   cmp_a..cmp_e       comparator operands: center, up, down, left, right
//   cmp_mayor          comparator result (combinational from cmp_a..cmp_e)
//   wr_en, wr_addr,
//   wr_data            destination RAM write port
//
// Build option:
//   DILATACION_WR_READY_EN  adds input wr_ready. WRITE then holds wr_en and
//                           the address/data until wr_ready is high.
//
// state  | meaning
// IDLE   | waiting for start
// READ   | k=0..5: issue 5 neighbour reads, capture data one cycle later
// CMP    | operands stable, register comparator result
// WRITE  | strobe destination write, advance to next pixel
// DONE   | one-cycle done pulse
// -----------------------------------------------------------------------------
module dilatacion_ctrl #(
  parameter int IMG_W    = 16,
  parameter int IMG_H    = 16,
  parameter int PIX_W    = 8,
  parameter int ADDR_W   = 16,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [PIX_W-1:0]  rd_data,
`ifdef DILATACION_WR_READY_EN
  input  logic              wr_ready,
`endif
  output logic [PIX_W-1:0]  cmp_a,
  output logic [PIX_W-1:0]  cmp_b,
  output logic [PIX_W-1:0]  cmp_c,
  output logic [PIX_W-1:0]  cmp_d,
  output logic [PIX_W-1:0]  cmp_e,
  input  logic [PIX_W-1:0]  cmp_mayor,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [XW-1:0]     X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0]     Y_LAST = YW'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] W_A    = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] SRC_A  = ADDR_W'(SRC_BASE);
  localparam logic [ADDR_W-1:0] DST_A  = ADDR_W'(DST_BASE);
  localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CMP,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [2:0]        k_q;
  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;
  logic [ADDR_W-1:0] row_base_q;
  logic              busy_q, done_q, wr_en_q;
  logic [ADDR_W-1:0] rd_addr_q, wr_addr_q;
  logic [PIX_W-1:0]  wr_data_q;
  logic [PIX_W-1:0]  cmp_a_q, cmp_b_q, cmp_c_q, cmp_d_q, cmp_e_q;

  // Next-pixel coordinates and address terms
  logic [XW-1:0]     x_d;
  logic [YW-1:0]     y_d;
  logic [ADDR_W-1:0] row_base_d;
  logic [ADDR_W-1:0] ctr, ctr_next_px, rd_addr_d, wr_addr_d;
  logic [2:0]        k_d;
  logic              at_l, at_r, at_u, at_dn, frame_end, wr_go;

`ifdef DILATACION_WR_READY_EN
  assign wr_go = wr_ready;
`else
  assign wr_go = 1'b1;
`endif

  always_comb begin
    at_l      = (x_q == '0);
    at_r      = (x_q == X_LAST);
    at_u      = (y_q == '0);
    at_dn     = (y_q == Y_LAST);
    frame_end = at_r && at_dn;
    ctr       = SRC_A + row_base_q + ADDR_W'(x_q);
    wr_addr_d = DST_A + row_base_q + ADDR_W'(x_q);
    k_d       = k_q + 3'd1;

    // rd_addr is registered, so the address for read slot k+1 is prepared
    // during slot k. Out-of-image neighbours replicate the center.
    rd_addr_d = rd_addr_q;
    case (k_d)
      3'd1: rd_addr_d = at_u  ? ctr : ctr - W_A;
      3'd2: rd_addr_d = at_dn ? ctr : ctr + W_A;
      3'd3: rd_addr_d = at_l  ? ctr : ctr - ONE_A;
      3'd4: rd_addr_d = at_r  ? ctr : ctr + ONE_A;
      default: rd_addr_d = rd_addr_q;
    endcase

    if (at_r) begin
      x_d        = '0;
      y_d        = y_q + YW'(1);
      row_base_d = row_base_q + W_A;
    end else begin
      x_d        = x_q + XW'(1);
      y_d        = y_q;
      row_base_d = row_base_q;
    end
    ctr_next_px = SRC_A + row_base_d + ADDR_W'(x_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      x_q        <= '0;
      y_q        <= '0;
      row_base_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      cmp_a_q    <= '0;
      cmp_b_q    <= '0;
      cmp_c_q    <= '0;
      cmp_d_q    <= '0;
      cmp_e_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            x_q        <= '0;
            y_q        <= '0;
            row_base_q <= '0;
            k_q        <= '0;
            rd_addr_q  <= SRC_A;
            busy_q     <= 1'b1;
            state_q    <= S_READ;
          end
        end
        S_READ: begin
          k_q       <= k_d;
          rd_addr_q <= rd_addr_d;
          // Data for slot k-1 arrives during slot k.
          case (k_q)
            3'd1: cmp_a_q <= rd_data;
            3'd2: cmp_b_q <= rd_data;
            3'd3: cmp_c_q <= rd_data;
            3'd4: cmp_d_q <= rd_data;
            3'd5: cmp_e_q <= rd_data;
            default: ;
          endcase
          if (k_q == 3'd5) state_q <= S_CMP;
        end
        S_CMP: begin
          wr_data_q <= cmp_mayor;
          wr_addr_q <= wr_addr_d;
          wr_en_q   <= 1'b1;
          state_q   <= S_WRITE;
        end
        S_WRITE: begin
          if (wr_go) begin
            wr_en_q <= 1'b0;
            if (frame_end) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              x_q        <= x_d;
              y_q        <= y_d;
              row_base_q <= row_base_d;
              k_q        <= '0;
              rd_addr_q  <= ctr_next_px;
              state_q    <= S_READ;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rd_addr = rd_addr_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign cmp_a   = cmp_a_q;
  assign cmp_b   = cmp_b_q;
  assign cmp_c   = cmp_c_q;
  assign cmp_d   = cmp_d_q;
  assign cmp_e   = cmp_e_q;

endmodule

// File: doc/dilatacion_ctrl.md
Name: dilatacion_ctrl

Overview:
- Sequencer for the 5-input max comparator in the dilation (max) filter path.
- Scans a grayscale image held in a synchronous-read source RAM and gathers the cross-shaped neighbourhood of each pixel: center, up, down, left, right.
- Presents the five operands to the external comparator, captures its maximum, and writes it to a destination RAM.
- Sits between the frame memories and the comparator; driven by a start/busy/done handshake from the top-level control.

Parameters:
- IMG_W, 16, image width in pixels (>=1)
- IMG_H, 16, image height in pixels (>=1)
- PIX_W, 8, pixel width in bits
- ADDR_W, 16, RAM address width
- SRC_BASE, 0, source image base address
- DST_BASE, 256, destination image base address

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a frame; sampled in IDLE only
- busy  out  1  high from the cycle after start is accepted until DONE is left
- done  out  1  one-cycle pulse at frame end
- rd_addr  out  ADDR_W  source RAM read address; data returns 1 cycle later
- rd_data  in  PIX_W  source RAM read data
- cmp_a..cmp_e  out  PIX_W each  comparator operands: center, up, down, left, right
- cmp_mayor  in  PIX_W  comparator result (combinational from cmp_a..cmp_e)
- wr_en  out  1  destination write strobe
- wr_addr  out  ADDR_W  destination address
- wr_data  out  PIX_W  destination data

Behaviour:
- Reset: all outputs 0, including the cmp_a..cmp_e registers; x=y=0; state IDLE. Reset mid-frame aborts immediately, no further write, no done.
- States: IDLE -> READ -> CMP -> WRITE -> (READ | DONE) -> IDLE.
- IDLE: when start=1, clear x, y and row_base, then go to READ. start is ignored in all other states.
- READ: counter k = 0..5.
  - For k = 0..4, rd_addr = address of neighbour k, in the order center, up, down, left, right.
  - For k = 1..5, rd_data is captured into operand k-1 (cmp_a..cmp_e).
  - READ lasts 6 cycles.
- Address generation:
  - Center = SRC_BASE + row_base + x, where row_base = y*IMG_W is accumulated by adding IMG_W per row; no multiplier.
  - Up = center - IMG_W; down = center + IMG_W; left = center - 1; right = center + 1.
  - Edge replicate: any out-of-image neighbour (y=0 up, y=IMG_H-1 down, x=0 left, x=IMG_W-1 right) reads the center address instead.
  - All address sums are truncated to ADDR_W.
- CMP: 1 cycle. Operands are held stable; cmp_mayor is registered into wr_data.
- WRITE: wr_en=1 for exactly 1 cycle, wr_addr = DST_BASE + row_base + x. Then:
  - x == IMG_W-1 and y == IMG_H-1: go to DONE.
  - x == IMG_W-1 otherwise: x=0, y+1, row_base += IMG_W, go to READ.
  - otherwise: x+1, go to READ.
- DONE: done=1 for 1 cycle, busy drops, return to IDLE.
- Cadence: 8 cycles per pixel. The first wr_en occurs in the 8th cycle after the start-accept edge. A frame takes IMG_W*IMG_H*8 + 1 cycles from busy rise to the done pulse.
- Degenerate sizes: IMG_W=1 and/or IMG_H=1 are legal; the affected neighbours all replicate the center.
- wr_en is 0 in every state except WRITE. cmp_* hold their last values between pixels.

Optional Feature:
- Macro: DILATACION_WR_READY_EN.
- Defined: adds input wr_ready (1 bit). WRITE holds wr_en=1 with wr_addr and wr_data stable until the cycle wr_ready=1; the state advances on that cycle. This is the only added latency.
- Undefined: port absent; WRITE is always 1 cycle as above.

Test Plan:
- Reset then idle: rst_n low mid-sim -> all outputs 0 asynchronously; with start=0 for 20 cycles, no rd/wr activity.
- 3x3 image, IMG_W=IMG_H=3, src = 0x10..0x18 row-major, start pulse:
  - exactly 9 writes to DST_BASE+0..8, done pulse at cycle 73 after busy rise;
  - dst[4] = max(0x14,0x11,0x17,0x13,0x15) = 0x17;
  - dst[0] = 0x13.
- Ties: center 0x84, up 0x87, down 0x84, left 0x87, right 0x84 -> wr_data 0x87.
- Edge replicate, corner pixel (0,0): rd_addr sequence SRC_BASE+0, +0, +IMG_W, +0, +1.
- Robustness: start re-asserted while busy -> ignored, write count unchanged. rst_n pulsed after the 4th write -> no 5th write, no done; a new start restarts at pixel (0,0).
- DILATACION_WR_READY_EN: wr_ready held 0 for 3 cycles on pixel 2 -> wr_en high 4 cycles with stable addr/data, frame length +3 cycles; without the macro, single-cycle writes.
